// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle of the synchronous FIFO: write-pointer input, memory read port,
// pointer feedback to the write side and the downstream valid/ready stream.
interface fifo_read_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH:0]   write_ptr;
  logic [ADDR_WIDTH:0]   read_ptr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  ptr_err;

  modport master (
    input  write_ptr, read_data, rd_ready,
    output read_ptr, read_addr, read_enable, rd_data, rd_valid, fifo_empty, rd_count, ptr_err
  );

  modport slave (
    output write_ptr, read_data, rd_ready,
    input  read_ptr, read_addr, read_enable, rd_data, rd_valid, fifo_empty, rd_count, ptr_err
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: issues memory reads ahead of demand and hides the
// one-cycle registered read latency behind a 2-entry in-order output buffer.
module fifo_read_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_read_ctrl_if.master bus
);

  generate
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
      $error("fifo_read_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0]   r_read_ptr;
  logic [1:0]            r_buf_cnt;
  logic                  r_inflight;
  logic                  r_rd_valid;
  logic                  r_ptr_err;
  logic [DATA_WIDTH-1:0] r_buf [2];

  logic                  w_fifo_empty;
  logic [ADDR_WIDTH:0]   w_rd_count;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic [1:0]            w_slot;
  logic [1:0]            w_buf_cnt_next;
  logic [DATA_WIDTH-1:0] w_head_next;
  logic [DATA_WIDTH-1:0] w_tail_next;

  assign w_fifo_empty = (bus.write_ptr == r_read_ptr);
  assign w_rd_count   = bus.write_ptr - r_read_ptr;
  assign w_pop        = r_rd_valid & bus.rd_ready;

  // Occupancy after this edge if nothing new is issued; keeps buf_cnt + inflight <= 2.
  assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = !rst && !w_fifo_empty && (w_occ < 3'd2);

  // Capture lands in the slot just past the surviving entries.
  assign w_slot         = r_buf_cnt - {1'b0, w_pop};
  assign w_buf_cnt_next = w_occ[1:0];

  always_comb begin
    w_head_next = r_buf[0];
    w_tail_next = r_buf[1];
    if (w_pop) begin
      w_head_next = r_buf[1];
    end
    if (r_inflight) begin
      if (w_slot == 2'd0) begin
        w_head_next = bus.read_data;
      end else begin
        w_tail_next = bus.read_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_ptr <= '0;
      r_buf_cnt  <= '0;
      r_inflight <= 1'b0;
      r_rd_valid <= 1'b0;
      r_ptr_err  <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_read_ptr <= r_read_ptr + 1'b1;
      end
      r_buf_cnt  <= w_buf_cnt_next;
      r_rd_valid <= (w_buf_cnt_next != 2'd0);
      r_buf[0]   <= w_head_next;
      r_buf[1]   <= w_tail_next;
      if (w_rd_count > DEPTH_W) begin
        r_ptr_err <= 1'b1;
      end
    end
  end

  assign bus.read_ptr    = r_read_ptr;
  assign bus.read_addr   = r_read_ptr[ADDR_WIDTH-1:0];
  assign bus.read_enable = w_issue;
  assign bus.rd_data     = r_buf[0];
  assign bus.rd_valid    = r_rd_valid;
  assign bus.fifo_empty  = w_fifo_empty;
  assign bus.rd_count    = w_rd_count;
  assign bus.ptr_err     = r_ptr_err;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a model memory and write side feed the DUT and a
// scoreboard queue holds the expected output word order.
module tb_fifo_read_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_read_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fifo_read_ctrl #(.ADDR_WIDTH(AW), .DEPTH(16), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Memory with registered read port
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (bus.read_enable) bus.read_data <= mem[bus.read_addr];
  end

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [AW:0]   wp;
  logic [DW-1:0] exp_q [$];
  bit            neg_done = 0;
  bit            mon_en = 1;
  bit            hold_pend;
  logic [DW-1:0] hold_data;
  int            pops, first_pop, last_pop, toggles;
  bit            prev_msb, saw_wrap;
  logic [AW-1:0] last_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic mon();
    if (rst) begin
      hold_pend = 0; pops = 0; first_pop = -1; last_pop = -1;
      toggles = 0; prev_msb = 0; saw_wrap = 0; last_addr = '0;
      return;
    end
    if (bus.read_ptr[AW] != prev_msb) toggles++;
    prev_msb = bus.read_ptr[AW];
    if (bus.read_enable) begin
      if (last_addr == 4'd15 && bus.read_addr == 4'd0) saw_wrap = 1;
      last_addr = bus.read_addr;
    end
    if (mon_en) begin
      if (hold_pend) check_val("hold_data", 32'(bus.rd_data), 32'(hold_data));
      hold_pend = bus.rd_valid && !bus.rd_ready;
      hold_data = bus.rd_data;
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0) begin
          check_val("pop_underrun", 32'(exp_q.size()), 32'd1);
        end else begin
          check_val("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        end
        $display("cycle %0d pop %0d data %h", cyc, pops, bus.rd_data);
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  endtask

  // tick: advance past the next rising edge (monitoring its preceding negedge once)
  task automatic tick();
    if (!neg_done) begin
      @(negedge clk);
      mon();
    end
    @(posedge clk);
    #1;
    cyc++;
    neg_done = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
    neg_done = 1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wp[AW-1:0]] = d;
    exp_q.push_back(d);
    wp = wp + 1'b1;
    bus.write_ptr = wp;
  endtask

  task automatic reset_dut();
    tick();
    rst = 1;
    wp = '0;
    bus.write_ptr = '0;
    exp_q.delete();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
    sample();
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  logic [AW:0] diff;
  int          nw;

  initial begin
    rst = 1;
    wp = '0;
    bus.write_ptr = '0;
    bus.rd_ready = 0;

    // 1. reset
    tick(); tick();
    sample();
    check_val("rst_valid",   32'(bus.rd_valid), 32'd0);
    check_val("rst_ren",     32'(bus.read_enable), 32'd0);
    check_val("rst_rptr",    32'(bus.read_ptr), 32'd0);
    check_val("rst_empty",   32'(bus.fifo_empty), 32'd1);
    check_val("rst_count",   32'(bus.rd_count), 32'd0);
    check_val("rst_rdata",   32'(bus.rd_data), 32'd0);
    check_val("rst_perr",    32'(bus.ptr_err), 32'd0);
    tick();
    rst = 0;

    // 2. single word latency
    bus.rd_ready = 1;
    tick();
    write_word(16'hA5A5);
    sample();
    check_val("s_ren",    32'(bus.read_enable), 32'd1);
    check_val("s_raddr",  32'(bus.read_addr), 32'd0);
    tick(); sample();
    check_val("s_valid_w1", 32'(bus.rd_valid), 32'd0);
    tick(); sample();
    check_val("s_valid_w2", 32'(bus.rd_valid), 32'd1);
    check_val("s_data",     32'(bus.rd_data), 32'h0000A5A5);
    tick(); sample();
    check_val("s_rptr",   32'(bus.read_ptr), 32'd1);
    check_val("s_empty",  32'(bus.fifo_empty), 32'd1);
    check_val("s_valid_end", 32'(bus.rd_valid), 32'd0);

    // 3. streaming, no bubbles
    reset_dut();
    bus.rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      write_word(16'(i));
    end
    drain("st_drain");
    check_val("st_pops",  32'(pops), 32'd16);
    check_val("st_span",  32'(last_pop - first_pop + 1), 32'd16);
    check_val("st_rptr",  32'(bus.read_ptr), 32'd16);

    // 4. backpressure
    reset_dut();
    bus.rd_ready = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      write_word(16'(i));
    end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      sample();
      check_val("bp_rptr",  32'(bus.read_ptr), 32'd2);
      check_val("bp_valid", 32'(bus.rd_valid), 32'd1);
      check_val("bp_data",  32'(bus.rd_data), 32'd0);
      check_val("bp_ren",   32'(bus.read_enable), 32'd0);
      check_val("bp_count", 32'(bus.rd_count), 32'd14);
      tick();
    end
    bus.rd_ready = 1;
    drain("bp_drain");
    check_val("bp_pops", 32'(pops), 32'd16);

    // 5. wrap with random stalls
    reset_dut();
    nw = 0;
    for (int k = 0; k < 2000 && nw < 40; k++) begin
      tick();
      bus.rd_ready = 1'($urandom_range(0, 1));
      diff = wp - bus.read_ptr;
      if (diff < 5'd16) begin
        write_word(16'h0100 + 16'(nw));
        nw++;
      end
    end
    check_val("wr_written", 32'(nw), 32'd40);
    bus.rd_ready = 1;
    drain("wr_drain");
    check_val("wr_pops",    32'(pops), 32'd40);
    check_val("wr_rptr",    32'(bus.read_ptr), 32'd8);
    check_val("wr_toggles", 32'(toggles), 32'd2);
    check_val("wr_addrwrap", 32'(saw_wrap), 32'd1);
    check_val("wr_count",   32'(bus.rd_count), 32'd0);
    check_val("wr_empty",   32'(bus.fifo_empty), 32'd1);

    // 6a. reset mid-operation with buffered and in-flight words
    reset_dut();
    bus.rd_ready = 0;
    tick(); write_word(16'h1111);
    tick(); write_word(16'h2222);
    tick(); write_word(16'h3333);
    sample();
    check_val("mr_pre_valid", 32'(bus.rd_valid), 32'd1);
    check_val("mr_pre_rptr",  32'(bus.read_ptr), 32'd2);
    tick();
    rst = 1;
    wp = '0;
    bus.write_ptr = '0;
    exp_q.delete();
    sample();
    check_val("mr_ren_in_rst", 32'(bus.read_enable), 32'd0);
    tick();
    rst = 0;
    sample();
    check_val("mr_valid", 32'(bus.rd_valid), 32'd0);
    check_val("mr_rptr",  32'(bus.read_ptr), 32'd0);
    check_val("mr_empty", 32'(bus.fifo_empty), 32'd1);

    // 6b. pointer error is sticky until reset
    mon_en = 0;
    tick();
    wp = 5'd17;
    bus.write_ptr = wp;
    sample();
    check_val("pe_count", 32'(bus.rd_count), 32'd17);
    check_val("pe_pre",   32'(bus.ptr_err), 32'd0);
    tick(); sample();
    check_val("pe_set",   32'(bus.ptr_err), 32'd1);
    tick();
    wp = bus.read_ptr;
    bus.write_ptr = wp;
    tick(); tick(); sample();
    check_val("pe_zero_count", 32'(bus.rd_count), 32'd0);
    check_val("pe_sticky",     32'(bus.ptr_err), 32'd1);
    reset_dut();
    sample();
    check_val("pe_cleared", 32'(bus.ptr_err), 32'd0);
    mon_en = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
